// File: rtl/ofd_uart_top.sv
// 8N1 UART: independent receiver and transmitter in one clock domain.
// Optional build macro OFD_UART_ECHO_EN: retransmit every valid received byte.
module ofd_uart_top #(
   parameter int CLK_FREQ = 100000000,
   parameter int BAUDRATE = 115200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       tx,
   input  logic       rx,
   input  logic       trig_start
);

   localparam int BIT_CYCLES = CLK_FREQ / BAUDRATE;
   localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_CYCLES / 2 - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_e;

   logic             rx_meta_q;
   logic             rx_sync_q;
   state_e           rx_state_q;
   logic [CNT_W-1:0] rx_cnt_q;
   logic [2:0]       rx_bit_q;
   logic [7:0]       rx_shift_q;
   logic [7:0]       data_out_q;

   state_e           tx_state_q;
   logic [CNT_W-1:0] tx_cnt_q;
   logic [2:0]       tx_bit_q;
   logic [7:0]       tx_shift_q;
   logic             tx_q;

   logic             rx_stop_ok_s;
   logic             tx_load_s;
   logic [7:0]       tx_load_data_s;

   assign rx_stop_ok_s = (rx_state_q == ST_STOP) && (rx_cnt_q == CNT_LAST) && rx_sync_q;

   // Two-flop synchroniser for the asynchronous rx pin, idles high.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   // Receiver FSM: half-bit start qualification, then mid-bit sampling.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state_q <= ST_IDLE;
         rx_cnt_q   <= CNT_ZERO;
         rx_bit_q   <= 3'd0;
         rx_shift_q <= 8'h00;
         data_out_q <= 8'h00;
      end else begin
         case (rx_state_q)
            ST_IDLE: begin
               rx_cnt_q <= CNT_ZERO;
               if (!rx_sync_q) begin
                  rx_state_q <= ST_START;
               end
            end
            ST_START: begin
               if (rx_cnt_q == CNT_HALF) begin
                  rx_cnt_q   <= CNT_ZERO;
                  rx_bit_q   <= 3'd0;
                  rx_state_q <= rx_sync_q ? ST_IDLE : ST_DATA;
               end else begin
                  rx_cnt_q <= rx_cnt_q + CNT_ONE;
               end
            end
            ST_DATA: begin
               if (rx_cnt_q == CNT_LAST) begin
                  rx_cnt_q             <= CNT_ZERO;
                  rx_shift_q[rx_bit_q] <= rx_sync_q;
                  if (rx_bit_q == 3'd7) begin
                     rx_state_q <= ST_STOP;
                  end else begin
                     rx_bit_q <= rx_bit_q + 3'd1;
                  end
               end else begin
                  rx_cnt_q <= rx_cnt_q + CNT_ONE;
               end
            end
            ST_STOP: begin
               // Framing errors (stop bit low) leave the last good byte in place.
               if (rx_cnt_q == CNT_LAST) begin
                  rx_cnt_q   <= CNT_ZERO;
                  rx_state_q <= ST_IDLE;
                  if (rx_sync_q) begin
                     data_out_q <= rx_shift_q;
                  end
               end else begin
                  rx_cnt_q <= rx_cnt_q + CNT_ONE;
               end
            end
            default: begin
               rx_state_q <= ST_IDLE;
               rx_cnt_q   <= CNT_ZERO;
            end
         endcase
      end
   end

`ifdef OFD_UART_ECHO_EN
   logic [7:0] echo_q;
   logic       echo_pend_q;
   logic       echo_take_s;

   // Transmit source select: a direct request wins over a pending echo.
   always_comb begin
      tx_load_s      = 1'b0;
      tx_load_data_s = data_in;
      echo_take_s    = 1'b0;
      if (tx_state_q == ST_IDLE) begin
         if (trig_start) begin
            tx_load_s      = 1'b1;
            tx_load_data_s = data_in;
         end else if (echo_pend_q) begin
            tx_load_s      = 1'b1;
            tx_load_data_s = echo_q;
            echo_take_s    = 1'b1;
         end else begin
            tx_load_s = 1'b0;
         end
      end else begin
         tx_load_s = 1'b0;
      end
   end

   // One-byte echo buffer; a newly received byte overwrites a pending one.
   always_ff @(posedge clk) begin
      if (reset) begin
         echo_q      <= 8'h00;
         echo_pend_q <= 1'b0;
      end else if (rx_stop_ok_s) begin
         echo_q      <= rx_shift_q;
         echo_pend_q <= 1'b1;
      end else if (echo_take_s) begin
         echo_pend_q <= 1'b0;
      end else begin
         echo_pend_q <= echo_pend_q;
      end
   end
`else
   // Transmit source select: only the external request can start a frame.
   always_comb begin
      tx_load_s      = 1'b0;
      tx_load_data_s = data_in;
      if ((tx_state_q == ST_IDLE) && trig_start) begin
         tx_load_s = 1'b1;
      end else begin
         tx_load_s = 1'b0;
      end
   end
`endif

   // Transmitter FSM with registered line output; shift register drains LSB first.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_q <= ST_IDLE;
         tx_cnt_q   <= CNT_ZERO;
         tx_bit_q   <= 3'd0;
         tx_shift_q <= 8'h00;
         tx_q       <= 1'b1;
      end else begin
         case (tx_state_q)
            ST_IDLE: begin
               tx_cnt_q <= CNT_ZERO;
               tx_q     <= 1'b1;
               if (tx_load_s) begin
                  tx_shift_q <= tx_load_data_s;
                  tx_q       <= 1'b0;
                  tx_state_q <= ST_START;
               end
            end
            ST_START: begin
               if (tx_cnt_q == CNT_LAST) begin
                  tx_cnt_q   <= CNT_ZERO;
                  tx_bit_q   <= 3'd0;
                  tx_q       <= tx_shift_q[0];
                  tx_state_q <= ST_DATA;
               end else begin
                  tx_cnt_q <= tx_cnt_q + CNT_ONE;
               end
            end
            ST_DATA: begin
               if (tx_cnt_q == CNT_LAST) begin
                  tx_cnt_q <= CNT_ZERO;
                  if (tx_bit_q == 3'd7) begin
                     tx_q       <= 1'b1;
                     tx_state_q <= ST_STOP;
                  end else begin
                     tx_bit_q   <= tx_bit_q + 3'd1;
                     tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                     tx_q       <= tx_shift_q[1];
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q + CNT_ONE;
               end
            end
            ST_STOP: begin
               if (tx_cnt_q == CNT_LAST) begin
                  tx_cnt_q   <= CNT_ZERO;
                  tx_state_q <= ST_IDLE;
               end else begin
                  tx_cnt_q <= tx_cnt_q + CNT_ONE;
               end
            end
            default: begin
               tx_state_q <= ST_IDLE;
               tx_cnt_q   <= CNT_ZERO;
               tx_q       <= 1'b1;
            end
         endcase
      end
   end

   assign data_out = data_out_q;
   assign tx       = tx_q;

endmodule

// File: tb/tb_ofd_uart_top.sv
// Directed bench for ofd_uart_top, run at 100 clocks per bit to keep frames short.
module tb_ofd_uart_top;

   localparam int CLK_FREQ = 100000000;
   localparam int BAUDRATE = 1000000;
   localparam int BC       = 100;

   logic       clk        = 1'b0;
   logic       reset      = 1'b1;
   logic       rx         = 1'b1;
   logic       trig_start = 1'b0;
   logic [7:0] data_in    = 8'h00;
   logic [7:0] data_out;
   logic       tx;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] vec [8] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h4D, 8'hC3};

   ofd_uart_top #(
      .CLK_FREQ(CLK_FREQ),
      .BAUDRATE(BAUDRATE)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .data_in   (data_in),
      .data_out  (data_out),
      .tx        (tx),
      .rx        (rx),
      .trig_start(trig_start)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rx_send(input logic [7:0] b, input logic stop_bit);
      logic [9:0] f;
      f = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = f[i];
         wait_clks(BC);
      end
   endtask

   // Finds the start bit, then samples every bit at its middle.
   task automatic tx_capture(output logic [7:0] b, output logic s, output logic p, output logic ok);
      int guard;
      guard = 0;
      b = 8'h00;
      s = 1'b1;
      p = 1'b0;
      while (tx !== 1'b0 && guard < 4 * BC) begin
         wait_clks(1);
         guard++;
      end
      ok = (tx === 1'b0);
      if (ok) begin
         wait_clks(BC / 2 - 1);
         s = tx;
         for (int i = 0; i < 8; i++) begin
            wait_clks(BC);
            b[i] = tx;
         end
         wait_clks(BC);
         p = tx;
      end
   endtask

   initial begin
      logic [7:0] got_b;
      logic       got_s, got_p, got_ok;
      logic [9:0] rf;
      int         lows;

      // Reset
      wait_clks(5);
      check_val("reset_data_out", {24'd0, data_out}, 32'h00);
      check_val("reset_tx", {31'd0, tx}, 32'h1);
      reset = 1'b0;
      lows = 0;
      for (int i = 0; i < 2000; i++) begin
         wait_clks(1);
         if (tx !== 1'b1) lows++;
      end
      check_val("tx_idle_2000", lows, 0);
      check_val("data_out_idle", {24'd0, data_out}, 32'h00);

      // Single and back-to-back reception
      wait_clks(10);
      rx_send(8'h4D, 1'b1);
      check_val("rx_single_4d", {24'd0, data_out}, 32'h4D);
      for (int i = 0; i < 8; i++) begin
         rx_send(vec[i], 1'b1);
         check_val($sformatf("rx_b2b_%0d", i), {24'd0, data_out}, {24'd0, vec[i]});
      end

      // Glitch and framing error
      rx = 1'b1;
      wait_clks(2 * BC);
      rx = 1'b0;
      wait_clks(20);
      rx = 1'b1;
      wait_clks(3 * BC);
      check_val("rx_glitch", {24'd0, data_out}, 32'hC3);
      rx_send(8'hA5, 1'b0);
      rx = 1'b1;
      wait_clks(2 * BC);
      check_val("rx_framing", {24'd0, data_out}, 32'hC3);
      rx_send(8'h3C, 1'b1);
      check_val("rx_after_framing", {24'd0, data_out}, 32'h3C);

      // Transmit frames; data_in is disturbed after latching
      for (int i = 0; i < 8; i++) begin
         data_in    = vec[i];
         trig_start = 1'b1;
         wait_clks(1);
         trig_start = 1'b0;
         data_in    = ~vec[i];
         fork
            tx_capture(got_b, got_s, got_p, got_ok);
            begin
               if (i == 0) begin
                  wait_clks(300);
                  trig_start = 1'b1;
                  wait_clks(1);
                  trig_start = 1'b0;
               end
            end
         join
         check_val($sformatf("tx_found_%0d", i), {31'd0, got_ok}, 32'h1);
         check_val($sformatf("tx_start_%0d", i), {31'd0, got_s}, 32'h0);
         check_val($sformatf("tx_byte_%0d", i), {24'd0, got_b}, {24'd0, vec[i]});
         check_val($sformatf("tx_stop_%0d", i), {31'd0, got_p}, 32'h1);
         wait_clks(60);
         check_val($sformatf("tx_no_requeue_%0d", i), {31'd0, tx}, 32'h1);
      end

      // Abort both directions in data bit 4
      rf      = {1'b1, 8'h5A, 1'b0};
      data_in = 8'hE5;
      for (int c = 0; c < 550; c++) begin
         rx         = rf[c / BC];
         trig_start = (c == 0);
         wait_clks(1);
      end
      check_val("tx_pre_abort", {31'd0, tx}, 32'h0);
      check_val("rx_pre_abort", {24'd0, data_out}, 32'h3C);
      reset = 1'b1;
      wait_clks(1);
      check_val("tx_abort", {31'd0, tx}, 32'h1);
      check_val("rx_abort", {24'd0, data_out}, 32'h00);
      reset = 1'b0;
      rx    = 1'b1;
      wait_clks(3 * BC);
      check_val("tx_after_abort", {31'd0, tx}, 32'h1);
      check_val("rx_after_abort", {24'd0, data_out}, 32'h00);

      // Full duplex 8'h81 after the abort
      data_in    = 8'h81;
      trig_start = 1'b1;
      wait_clks(1);
      trig_start = 1'b0;
      fork
         rx_send(8'h81, 1'b1);
         tx_capture(got_b, got_s, got_p, got_ok);
      join
      check_val("fd_rx_81", {24'd0, data_out}, 32'h81);
      check_val("fd_tx_found", {31'd0, got_ok}, 32'h1);
      check_val("fd_tx_start", {31'd0, got_s}, 32'h0);
      check_val("fd_tx_81", {24'd0, got_b}, 32'h81);
      check_val("fd_tx_stop", {31'd0, got_p}, 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
